// File: rtl/led_pattern_seq_if.sv
// Control/config and LED-counter side of the pattern sequencer.
// The master drives config and start/stop; the slave is the sequencer.
interface led_pattern_seq_if #(
    parameter int DEPTH   = 8,
    parameter int DIV_W   = 5,
    parameter int DWELL_W = 8
);
    localparam int AW = $clog2(DEPTH);

    logic               cfg_we_i;
    logic [AW-1:0]      cfg_addr_i;
    logic [DIV_W-1:0]   cfg_div_i;
    logic [DWELL_W-1:0] cfg_dwell_i;
    logic [AW:0]        len_i;
    logic               loop_i;
    logic               start_i;
    logic               stop_i;
    logic [DIV_W-1:0]   div_o;
    logic               wren_o;
    logic [AW-1:0]      idx_o;
    logic               busy_o;
    logic               done_o;

    modport master (
        output cfg_we_i, cfg_addr_i, cfg_div_i, cfg_dwell_i, len_i, loop_i, start_i, stop_i,
        input  div_o, wren_o, idx_o, busy_o, done_o
    );

    modport slave (
        input  cfg_we_i, cfg_addr_i, cfg_div_i, cfg_dwell_i, len_i, loop_i, start_i, stop_i,
        output div_o, wren_o, idx_o, busy_o, done_o
    );
endinterface

// File: rtl/led_pattern_seq.sv
// Steps an LED blink counter through a table of (divisor, dwell) entries,
// holding each divisor for dwell * TICK_CNT cycles, once or looping.
module led_pattern_seq #(
    parameter int DEPTH    = 8,
    parameter int TICK_CNT = 100000000,
    parameter int DIV_W    = 5,
    parameter int DWELL_W  = 8
) (
    input logic              clk100,
    input logic              rst,
    led_pattern_seq_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CNT - 1);
    localparam logic [AW:0]   LEN_MAX   = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [DIV_W-1:0]   div;
        logic [DWELL_W-1:0] dwell;
    } entry_t;

    typedef enum logic [1:0] {IDLE, APPLY, DWELL} state_t;

    entry_t             tbl [DEPTH];
    state_t             state;
    logic [AW-1:0]      idx;
    logic [AW:0]        len;
    logic               loop;
    logic [TW-1:0]      tick;
    logic [DWELL_W-1:0] dwell;
    logic               fin;
    logic [DIV_W-1:0]   div_q;
    logic               wren_q;
    logic [AW-1:0]      idx_q;
    logic               busy_q;
    logic               done_q;

    // Non-blocking write: an APPLY of the same address on the same edge sees the old entry.
    always_ff @(posedge clk100) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
        end else if (bus.cfg_we_i) begin
            tbl[bus.cfg_addr_i] <= '{div: bus.cfg_div_i, dwell: bus.cfg_dwell_i};
        end
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            len    <= '0;
            loop   <= 1'b0;
            tick   <= '0;
            dwell  <= '0;
            fin    <= 1'b0;
            div_q  <= '0;
            wren_q <= 1'b0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            wren_q <= 1'b0;
            done_q <= 1'b0;
            if (bus.stop_i) begin
                state  <= IDLE;
                tick   <= '0;
                dwell  <= '0;
                fin    <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start_i && bus.len_i != '0) begin
                            len   <= (bus.len_i > LEN_MAX) ? LEN_MAX : bus.len_i;
                            loop  <= bus.loop_i;
                            idx   <= '0;
                            state <= APPLY;
                        end
                    end
                    APPLY: begin
                        div_q  <= tbl[idx].div;
                        wren_q <= 1'b1;
                        idx_q  <= idx;
                        busy_q <= 1'b1;
                        dwell  <= (tbl[idx].dwell == '0) ? DWELL_W'(1) : tbl[idx].dwell;
                        tick   <= '0;
                        state  <= DWELL;
                    end
                    DWELL: begin
                        // fin spends one extra cycle so done lands where the next wren would have.
                        if (fin) begin
                            fin    <= 1'b0;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else if (tick == TICK_LAST) begin
                            tick <= '0;
                            if (dwell > DWELL_W'(1)) begin
                                dwell <= dwell - 1'b1;
                            end else if ({1'b0, idx} != len - 1'b1) begin
                                idx   <= idx + 1'b1;
                                state <= APPLY;
                            end else if (loop) begin
                                idx   <= '0;
                                state <= APPLY;
                            end else begin
                                fin <= 1'b1;
                            end
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.div_o  = div_q;
    assign bus.wren_o = wren_q;
    assign bus.idx_o  = idx_q;
    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
endmodule

// File: doc/led_pattern_seq.md
# led_pattern_seq

Sequencer that drives the divisor and write-strobe inputs of an LED blink counter. It steps through a programmable table of up to 8 (divisor, dwell) entries and holds each divisor for a programmed number of dwell units, either once or looping. It sits between the control/config logic and the LED counter in the clk100 domain. The downstream `div`/`wren` ports connect directly to `div_o`/`wren_o`.

## Interface
Parameters:
- `DEPTH`, 8: number of table entries (power of 2).
- `TICK_CNT`, 100000000: clk100 cycles per dwell unit (1 s); benches override with small values.
- `DIV_W`, 5: divisor width.
- `DWELL_W`, 8: dwell field width, in dwell units.

Ports:
- `clk100` in 1: system clock, 100 MHz.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_we_i` in 1: table write strobe.
- `cfg_addr_i` in log2(DEPTH): table write address.
- `cfg_div_i` in DIV_W: divisor written to the entry.
- `cfg_dwell_i` in DWELL_W: dwell written to the entry.
- `len_i` in log2(DEPTH)+1: number of active entries, sampled at start.
- `loop_i` in 1: 1 = wrap to entry 0 after the last entry; sampled at start.
- `start_i` in 1: start request, level-sampled.
- `stop_i` in 1: abort request.
- `div_o` out DIV_W: divisor to the LED counter.
- `wren_o` out 1: one-cycle strobe on each entry change.
- `idx_o` out log2(DEPTH): current entry index.
- `busy_o` out 1: high while a sequence runs.
- `done_o` out 1: one-cycle pulse when a non-looping sequence completes.

## Operation
- States: IDLE, APPLY, DWELL.
- **IDLE**
  - `busy_o` = 0.
  - On `start_i` = 1 and `stop_i` = 0 and `len_i` != 0:
    - capture `len` = min(`len_i`, DEPTH) and `loop` = `loop_i`;
    - set `idx` = 0;
    - go to APPLY.
  - `start_i` with `len_i` = 0 is ignored.
- **APPLY** (exactly one cycle)
  - `div_o` <= table[idx].div; `wren_o` = 1.
  - Load the dwell counter with max(table[idx].dwell, 1) and clear the tick counter.
  - Go to DWELL.
- **DWELL**
  - The tick counter counts 0..TICK_CNT-1.
  - At terminal count, decrement the dwell counter.
  - When the final unit ends:
    - if idx < len-1: idx++, go to APPLY;
    - else if `loop`: idx = 0, go to APPLY;
    - else: pulse `done_o`, go to IDLE.
- **Stop**
  - `stop_i` in any state: go to IDLE on the next edge.
  - Clears tick and dwell counters. No `done_o`, no `wren_o`.
  - `div_o` holds its last value.
  - `stop_i` wins over `start_i` in the same cycle.
- **Ignored inputs:** `start_i` while busy; `len_i`/`loop_i` changes while busy.
- **Table writes**
  - Accepted in any state.
  - A write to the currently applied entry does not change `div_o` until that entry's next APPLY.
  - A write and an APPLY of the same address in the same cycle: APPLY reads the old value.
- **Width rules**
  - Dwell value 0 is treated as 1.
  - The tick counter is sized to hold TICK_CNT-1.
  - The dwell counter is DWELL_W bits and never underflows.

## Timing
- **Reset values:** `div_o` = 0, `wren_o` = 0, `idx_o` = 0, `busy_o` = 0, `done_o` = 0; all table entries 0/0; state IDLE.
- **Start latency:**
  - `start_i` sampled at edge N gives `busy_o` = 1, `wren_o` = 1, new `div_o`, and `idx_o` = 0 in the cycle after edge N+1 (APPLY registers outputs).
  - `wren_o` is high for exactly one cycle.
- **Entry period:** consecutive `wren_o` pulses are spaced exactly max(dwell,1)*TICK_CNT + 1 cycles apart. The +1 is the APPLY cycle.
- **Completion:** `done_o` pulses for one cycle at the time the next `wren_o` would have occurred. `busy_o` falls in that same cycle.
- **Index updates:** `idx_o` updates in the same cycle as `wren_o`. `div_o` and `idx_o` are stable between pulses.
- **Back-to-back runs:** a new `start_i` is accepted in the cycle `done_o` is high (state is IDLE) and restarts from idx 0.
- **Stop latency:** `busy_o` falls one cycle after `stop_i` is sampled.

## Test plan
- **Reset:** `rst` held 3 cycles, then released → all outputs 0 and `busy_o` = 0; `start_i` with `len_i` = 0 → no `wren_o`, `busy_o` stays 0.
- **Single pass:** TICK_CNT=4, entries {3/2, 7/1, 20/3}, `len_i` = 3, `loop_i` = 0, start → `wren_o` with `div_o` = 3, 7, 20 spaced 9 and 5 cycles apart; `done_o` 13 cycles after the third `wren_o`; `busy_o` = 0 afterwards.
- **Loop wrap:** same table, `loop_i` = 1 → after entry 2, `idx_o` returns to 0 and `div_o` = 3 with `wren_o`; no `done_o` over 3 passes.
- **Dwell zero and clamp:** entry dwell 0 gives a 5-cycle spacing (treated as 1); `len_i` = 15 with DEPTH = 8 runs exactly 8 entries.
- **Stop mid-dwell:** stop during entry 1 → `busy_o` = 0 next cycle, `div_o` holds 7, no `done_o`; `stop_i` and `start_i` together in IDLE → no start.
- **Live config write:** write entry 0 div = 9 while entry 0 is applied → `div_o` stays 3 until the loop's next APPLY of entry 0, then 9; a same-cycle write and APPLY of entry 0 yields the old value.
